// File: rtl/alu_req_arbiter_if.sv
// Request/response and ALU-side bus of the shared-ALU arbiter.
// master = arbiter, slave = requesters plus ALU.
interface alu_req_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       REQ_VALID;
    logic [N_REQ-1:0]       REQ_READY;
    logic [4*N_REQ-1:0]     REQ_FUN;
    logic [WIDTH*N_REQ-1:0] REQ_A;
    logic [WIDTH*N_REQ-1:0] REQ_B;
    logic [N_REQ-1:0]       RSP_VALID;
    logic [N_REQ-1:0]       RSP_READY;
    logic [WIDTH-1:0]       RSP_DATA;
    logic                   RSP_ERR;
    logic                   ALU_EN;
    logic [3:0]             ALU_FUN;
    logic [WIDTH-1:0]       ALU_A;
    logic [WIDTH-1:0]       ALU_B;
    logic [WIDTH-1:0]       ALU_OUT;
    logic                   ALU_OUT_VALID;

    modport master (
        input  REQ_VALID, REQ_FUN, REQ_A, REQ_B, RSP_READY, ALU_OUT, ALU_OUT_VALID,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ALU_EN, ALU_FUN, ALU_A, ALU_B
    );

    modport slave (
        output REQ_VALID, REQ_FUN, REQ_A, REQ_B, RSP_READY, ALU_OUT, ALU_OUT_VALID,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ALU_EN, ALU_FUN, ALU_A, ALU_B
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU among N_REQ requesters, with
// early rejection of illegal ops and a bounded wait for the ALU result.
module alu_req_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input logic                CLK,
    input logic                RST,
    alu_req_arbiter_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] grant_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       fun_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             alu_en_r;
    logic [N_REQ-1:0] rsp_valid_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;

    logic [PTR_W-1:0] grant_s;
    logic             found_s;
    logic             hs_s;
    logic             bad_op_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic [N_REQ-1:0] req_ready_s;
    logic [3:0]       sel_fun_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    logic [3:0]       fun_arr_s [N_REQ];
    logic [WIDTH-1:0] a_arr_s   [N_REQ];
    logic [WIDTH-1:0] b_arr_s   [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] g);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign fun_arr_s[gi] = bus.REQ_FUN[4*gi +: 4];
        assign a_arr_s[gi]   = bus.REQ_A[WIDTH*gi +: WIDTH];
        assign b_arr_s[gi]   = bus.REQ_B[WIDTH*gi +: WIDTH];
    end

    // Round-robin search: scanning downward lets the closest valid slot after ptr win.
    always_comb begin
        logic [PTR_W:0]   sum_v;
        logic [PTR_W-1:0] idx_v;
        grant_s = '0;
        found_s = 1'b0;
        sum_v   = '0;
        idx_v   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum_v = {1'b0, ptr_r} + (PTR_W+1)'(i);
            if (sum_v >= (PTR_W+1)'(N_REQ)) begin
                sum_v = sum_v - (PTR_W+1)'(N_REQ);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[PTR_W-1:0];
            if (bus.REQ_VALID[idx_v]) begin
                grant_s = idx_v;
                found_s = 1'b1;
            end else begin
                grant_s = grant_s;
                found_s = found_s;
            end
        end
    end

    // Handshake qualification, illegal-op detection and ready decode.
    always_comb begin
        sel_fun_s = fun_arr_s[grant_s];
        sel_a_s   = a_arr_s[grant_s];
        sel_b_s   = b_arr_s[grant_s];
        hs_s      = RST && (state_r == ST_IDLE) && found_s;
        bad_op_s  = (sel_fun_s == 4'b1111) ||
                    ((sel_fun_s == 4'b0011) && (sel_b_s == {WIDTH{1'b0}}));
        if (grant_s == PTR_W'(N_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_s + PTR_W'(1);
        end
        if (hs_s) begin
            req_ready_s = onehot(grant_s);
        end else begin
            req_ready_s = '0;
        end
    end

    // Main FSM: grant, issue, wait with timeout, hold response until accepted.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            grant_r     <= '0;
            cnt_r       <= '0;
            fun_r       <= 4'b0000;
            a_r         <= '0;
            b_r         <= '0;
            alu_en_r    <= 1'b0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            alu_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        grant_r <= grant_s;
                        ptr_r   <= ptr_next_s;
                        fun_r   <= sel_fun_s;
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        if (bad_op_s) begin
                            rsp_valid_r <= onehot(grant_s);
                            rsp_data_r  <= {WIDTH{1'b1}};
                            rsp_err_r   <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            alu_en_r <= 1'b1;
                            state_r  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.ALU_OUT_VALID) begin
                        rsp_valid_r <= onehot(grant_r);
                        rsp_data_r  <= bus.ALU_OUT;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_RESP;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid_r <= onehot(grant_r);
                        rsp_data_r  <= {WIDTH{1'b1}};
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.RSP_READY[grant_r]) begin
                        rsp_valid_r <= '0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY = req_ready_s;
    assign bus.RSP_VALID = rsp_valid_r;
    assign bus.RSP_DATA  = rsp_data_r;
    assign bus.RSP_ERR   = rsp_err_r;
    assign bus.ALU_EN    = alu_en_r;
    assign bus.ALU_FUN   = fun_r;
    assign bus.ALU_A     = a_r;
    assign bus.ALU_B     = b_r;
endmodule
